// File: rtl/serial_word_tx.sv
// rtl/serial_word_tx.sv - parallel-to-serial word transmitter with pending buffer and inter-frame gap
// Optional macro SERIAL_WORD_TX_REM5_EN adds the rem5/div5 modulo-5 reference ports.
module serial_word_tx #(
    parameter int WIDTH      = 16,
    parameter bit MSB_FIRST  = 1'b1,
    parameter int GAP_CYCLES = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_bit,
    output logic             out_first,
    output logic             out_last,
    output logic             busy
`ifdef SERIAL_WORD_TX_REM5_EN
    ,
    output logic [2:0]       rem5,
    output logic [0:0]       div5
`endif
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
    localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] pend;
    logic             pend_valid;
    logic [CW-1:0]    bit_cnt;
    logic [7:0]       gap_cnt;

    logic accept, xfer, frame_end, gap_done;
    logic ld_in, ld_pend, to_pend;

    assign s_ready   = !pend_valid;
    assign out_valid = (state == SHIFT);
    assign out_bit   = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
    assign out_first = (state == SHIFT) && (bit_cnt == '0);
    assign out_last  = (state == SHIFT) && (bit_cnt == LAST_BIT);
    assign busy      = (state != IDLE) || pend_valid;

    assign accept    = s_valid && s_ready;
    assign xfer      = out_valid && out_ready;
    assign frame_end = xfer && out_last;
    assign gap_done  = (state == GAP) && (gap_cnt == GAP_LAST);

    always_comb begin
        state_next = state;
        ld_in      = 1'b0;
        ld_pend    = 1'b0;
        to_pend    = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    ld_in      = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (frame_end) begin
                    if (GAP_CYCLES > 0) begin
                        state_next = GAP;
                        to_pend    = accept;
                    end else if (pend_valid) begin
                        ld_pend = 1'b1;
                    end else if (accept) begin
                        ld_in = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    to_pend = accept;
                end
            end
            GAP: begin
                if (gap_done) begin
                    if (pend_valid) begin
                        ld_pend    = 1'b1;
                        state_next = SHIFT;
                    end else if (accept) begin
                        ld_in      = 1'b1;
                        state_next = SHIFT;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    to_pend = accept;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // bit_cnt holds at frame end; only a reload returns it to zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg      <= '0;
            pend       <= '0;
            pend_valid <= 1'b0;
            bit_cnt    <= '0;
            gap_cnt    <= '0;
        end else begin
            if (ld_in) begin
                shreg   <= s_data;
                bit_cnt <= '0;
            end else if (ld_pend) begin
                shreg   <= pend;
                bit_cnt <= '0;
            end else if (xfer) begin
                shreg <= MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0} : {1'b0, shreg[WIDTH-1:1]};
                if (!out_last) begin
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end

            if (to_pend) begin
                pend       <= s_data;
                pend_valid <= 1'b1;
            end else if (ld_pend) begin
                pend_valid <= 1'b0;
            end

            gap_cnt <= (state == GAP) ? gap_cnt + 8'd1 : 8'd0;
        end
    end

`ifdef SERIAL_WORD_TX_REM5_EN
    logic [3:0] rem_dbl;
    logic [2:0] rem_next;

    always_comb begin
        rem_dbl  = {rem5, 1'b0} + {3'b000, out_bit};
        rem_next = (rem_dbl >= 4'd5) ? 3'(rem_dbl - 4'd5) : rem_dbl[2:0];
        if (out_first) begin
            rem_next = {2'b00, out_bit};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem5 <= 3'd0;
            div5 <= 1'b0;
        end else begin
            if (xfer) begin
                rem5 <= rem_next;
            end
            div5 <= frame_end && (rem_next == 3'd0);
        end
    end
`endif

endmodule

// File: tb/tb_serial_word_tx.sv
// tb/tb_serial_word_tx.sv - directed self-checking bench for serial_word_tx
// Instance 0: gap 0 MSB-first, instance 1: gap 2, instance 2: LSB-first.
module tb_serial_word_tx;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  s_valid = '0;
    logic [2:0]  out_ready = '0;
    logic [15:0] s_data [3];
    wire  [2:0]  s_ready, out_valid, out_bit, out_first, out_last, busy;
`ifdef SERIAL_WORD_TX_REM5_EN
    wire  [8:0]  rem5;
    wire  [2:0]  div5;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    serial_word_tx #(.WIDTH(16), .MSB_FIRST(1'b1), .GAP_CYCLES(0)) u_b2b (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid[0]), .s_ready(s_ready[0]), .s_data(s_data[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_bit(out_bit[0]),
        .out_first(out_first[0]), .out_last(out_last[0]), .busy(busy[0])
`ifdef SERIAL_WORD_TX_REM5_EN
        , .rem5(rem5[2:0]), .div5(div5[0:0])
`endif
    );

    serial_word_tx #(.WIDTH(16), .MSB_FIRST(1'b1), .GAP_CYCLES(2)) u_gap (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid[1]), .s_ready(s_ready[1]), .s_data(s_data[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_bit(out_bit[1]),
        .out_first(out_first[1]), .out_last(out_last[1]), .busy(busy[1])
`ifdef SERIAL_WORD_TX_REM5_EN
        , .rem5(rem5[5:3]), .div5(div5[1:1])
`endif
    );

    serial_word_tx #(.WIDTH(16), .MSB_FIRST(1'b0), .GAP_CYCLES(0)) u_lsb (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid[2]), .s_ready(s_ready[2]), .s_data(s_data[2]),
        .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_bit(out_bit[2]),
        .out_first(out_first[2]), .out_last(out_last[2]), .busy(busy[2])
`ifdef SERIAL_WORD_TX_REM5_EN
        , .rem5(rem5[8:6]), .div5(div5[2:2])
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Offers nw words back to back; reports s_ready one cycle after the last accept.
    task automatic feed(input int idx, input logic [15:0] w0, input logic [15:0] w1,
                        input int nw, output logic after_rdy);
        int i = 0;
        int c = 0;
        while (i < nw && c < 400) begin
            @(negedge clk);
            s_valid[idx] = 1'b1;
            s_data[idx]  = (i == 0) ? w0 : w1;
            if (s_ready[idx]) i++;
            c++;
        end
        @(negedge clk);
        s_valid[idx] = 1'b0;
        after_rdy = s_ready[idx];
        check("feed_done", 64'(i), 64'(nw));
    endtask

    // Drives out_ready from a 4-cycle pattern and records n transfers.
    task automatic collect(input int idx, input int n, input logic [3:0] pat,
                           output logic [63:0] word, output logic [63:0] fm, output logic [63:0] lm,
                           output int lat, output int gap16, output int gap_other, output int stab_err);
        int k = 0;
        int c = 0;
        int idle = 0;
        logic held = 1'b0;
        logic [2:0] hv = '0;
        logic r;
        word = '0; fm = '0; lm = '0; lat = -1; gap16 = 0; gap_other = 0; stab_err = 0;
        while (k < n && c < 400) begin
            @(negedge clk);
            if (held && (!out_valid[idx] || {out_bit[idx], out_first[idx], out_last[idx]} != hv))
                stab_err++;
            r = pat[c % 4];
            out_ready[idx] = r;
            if (out_valid[idx] && lat < 0) lat = c;
            if (out_valid[idx] && r) begin
                word = {word[62:0], out_bit[idx]};
                fm[k] = out_first[idx];
                lm[k] = out_last[idx];
                if (k == 16) gap16 = idle;
                else if (k > 0 && idle > gap_other) gap_other = idle;
                idle = 0;
                held = 1'b0;
                k++;
            end else begin
                if (!out_valid[idx] && k > 0) idle++;
                held = out_valid[idx];
                hv = {out_bit[idx], out_first[idx], out_last[idx]};
            end
            c++;
        end
        check("collect_done", 64'(k), 64'(n));
    endtask

    logic [63:0] word, fm, lm;
    int lat, gap16, gap_other, stab_err;
    logic after_rdy;
    int vcnt;

    initial begin
        for (int i = 0; i < 3; i++) s_data[i] = '0;
        repeat (3) @(negedge clk);
        check("reset_outputs", 64'({s_ready[0], out_valid[0], out_bit[0], out_first[0], out_last[0], busy[0]}),
              64'(6'b100000));
        rst_n = 1'b1;
        @(negedge clk);

        // single frame 0x000A
        fork
            feed(0, 16'h000A, 16'h0000, 1, after_rdy);
            collect(0, 16, 4'b1111, word, fm, lm, lat, gap16, gap_other, stab_err);
        join
        check("single_latency", 64'(lat), 64'd1);
        check("single_bits", word, 64'h000A);
        check("single_first", fm, 64'h0001);
        check("single_last", lm, 64'h8000);
        @(negedge clk);
        check("single_idle", 64'({out_valid[0], busy[0]}), 64'd0);
`ifdef SERIAL_WORD_TX_REM5_EN
        check("single_div5", 64'(div5[0]), 64'd1);
        check("single_rem5", 64'(rem5[2:0]), 64'd0);
`endif

        // backpressure 0xA5A5 with out_ready 1,0,0,1
        fork
            feed(0, 16'hA5A5, 16'h0000, 1, after_rdy);
            collect(0, 16, 4'b1001, word, fm, lm, lat, gap16, gap_other, stab_err);
        join
        check("bp_bits", word, 64'hA5A5);
        check("bp_first_last", {fm[31:0], lm[31:0]}, {32'h0001, 32'h8000});
        check("bp_stable", 64'(stab_err), 64'd0);
        out_ready[0] = 1'b1;
        vcnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid[0]) vcnt++;
        end
        check("bp_no_extra", 64'(vcnt), 64'd0);

        // back-to-back, no gap
        fork
            feed(0, 16'hFFFF, 16'h0001, 2, after_rdy);
            collect(0, 32, 4'b1111, word, fm, lm, lat, gap16, gap_other, stab_err);
        join
        check("b2b_bits", word, 64'hFFFF_0001);
        check("b2b_first", fm, 64'h0001_0001);
        check("b2b_last", lm, 64'h8000_8000);
        check("b2b_gaps", 64'({gap16, gap_other}), 64'd0);
        check("b2b_sready_full", 64'(after_rdy), 64'd0);
        @(negedge clk);
        check("b2b_idle", 64'(busy[0]), 64'd0);

        // two-cycle inter-frame gap
        fork
            feed(1, 16'h1234, 16'hABCD, 2, after_rdy);
            collect(1, 32, 4'b1111, word, fm, lm, lat, gap16, gap_other, stab_err);
        join
        check("gap_bits", word, 64'h1234_ABCD);
        check("gap_len", 64'(gap16), 64'd2);
        check("gap_other", 64'(gap_other), 64'd0);
        check("gap_first_last", {fm[31:0], lm[31:0]}, {32'h0001_0001, 32'h8000_8000});

        // LSB-first 0x0003
        fork
            feed(2, 16'h0003, 16'h0000, 1, after_rdy);
            collect(2, 16, 4'b1111, word, fm, lm, lat, gap16, gap_other, stab_err);
        join
        check("lsb_bits", word, 64'hC000);
        check("lsb_first_last", {fm[31:0], lm[31:0]}, {32'h0001, 32'h8000});

        // reset mid-frame with pending word held
        fork
            feed(0, 16'h1111, 16'h2222, 2, after_rdy);
            collect(0, 5, 4'b1111, word, fm, lm, lat, gap16, gap_other, stab_err);
        join
        @(negedge clk);
        out_ready[0] = 1'b0;
        check("rst_pre", 64'({busy[0], s_ready[0], out_valid[0]}), 64'(3'b101));
        rst_n = 1'b0;
        #1;
        check("rst_async", 64'({s_ready[0], out_valid[0], out_bit[0], out_first[0], out_last[0], busy[0]}),
              64'(6'b100000));
        @(negedge clk);
        rst_n = 1'b1;
        out_ready[0] = 1'b1;
        vcnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid[0] || busy[0]) vcnt++;
        end
        check("rst_quiet", 64'(vcnt), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_word_tx.md
Name: serial_word_tx

Overview:
Parallel-to-serial bitstream transmitter. It is the sending end for the team's serial bitstream consumers: sequence detectors and modulo checkers that take a bit input plus a last flag. It accepts fixed-width words over a valid/ready handshake and emits one bit per handshake on a valid/ready serial port, with first/last framing and a configurable inter-frame gap. A one-word pending buffer sustains back-to-back frames with no bubble.

Parameters:
- WIDTH, 16, bits per frame (2..64).
- MSB_FIRST, 1, 1 = bit WIDTH-1 sent first; 0 = bit 0 sent first.
- GAP_CYCLES, 0, idle cycles (out_valid low) forced between frames (0..255).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- s_valid  in  1  input word valid.
- s_ready  out  1  input buffer can accept a word.
- s_data  in  WIDTH  input word.
- out_valid  out  1  out_bit is valid.
- out_ready  in  1  downstream accepts the bit.
- out_bit  out  1  serial data bit.
- out_first  out  1  high with the first bit of a frame.
- out_last  out  1  high with the last bit of a frame.
- busy  out  1  active frame, gap in progress, or pending word held.

Behaviour:
- Reset (rst_n low, async): state=IDLE, all buffers empty, counters 0. Outputs: s_ready=1, out_valid=0, out_bit=0, out_first=0, out_last=0, busy=0.
- Storage is two word slots: the active shift register and a pending register. The pending register has a valid flag.
- s_ready = !pend_valid, driven from registers only. There is no combinational path from out_ready to s_ready.
- Input accept = s_valid && s_ready on a clk edge.
- Bit transfer = out_valid && out_ready on a clk edge.
- State IDLE:
  - Accept loads the word into the shift register, clears bit_cnt and goes to SHIFT.
  - The first bit appears on out_valid in the next cycle (latency 1).
- State SHIFT:
  - out_valid=1. out_bit = current MSB (MSB_FIRST=1) or LSB (MSB_FIRST=0).
  - out_first = (bit_cnt==0). out_last = (bit_cnt==WIDTH-1).
  - On each transfer the register shifts and bit_cnt increments.
  - With out_ready low, out_bit, out_first and out_last stay stable.
  - Accepts during SHIFT go to the pending register.
- Frame end (transfer with out_last=1):
  - GAP_CYCLES>0: go to GAP with gap_cnt=0.
  - GAP_CYCLES=0, pending valid: load pending into the shift register, clear pend_valid, stay in SHIFT. No bubble.
  - GAP_CYCLES=0, pending empty, accept in the same cycle: load the new word straight into the shift register, stay in SHIFT. No bubble.
  - Otherwise go to IDLE.
- State GAP:
  - out_valid=0. gap_cnt increments each cycle. Accepts go to pending.
  - When gap_cnt reaches GAP_CYCLES-1:
    - pending valid: load it, go to SHIFT.
    - pending empty, accept in the same cycle: load the new word directly, go to SHIFT.
    - otherwise go to IDLE.
- Width rules:
  - bit_cnt is $clog2(WIDTH) bits and wraps to 0 only via frame reload.
  - gap_cnt is 8 bits.
- busy = (state!=IDLE) || pend_valid.
- Reset mid-frame: the frame and any pending word are discarded. No partial out_last is ever emitted afterwards.
- out_valid never drops mid-frame. Once a frame starts, out_valid stays high until the out_last transfer.

Optional Feature:
- Macro SERIAL_WORD_TX_REM5_EN.
- Defined: adds two output ports.
  - rem5 [2:0]: running remainder of the frame's bits sent so far, interpreted MSB-first, modulo 5.
    - Update on each transfer: rem5 <= (rem5*2 + out_bit) % 5.
    - Cleared to 0 on reset and on the first-bit transfer, where it takes the value (out_bit % 5).
  - div5 [0:0]: pulses 1 for one cycle after the out_last transfer if the final rem5 == 0, otherwise 0.
  - Purpose: bench reference for modulo checkers. The ports are meaningful only with MSB_FIRST=1.
- Undefined: ports and logic are absent, and behaviour is otherwise identical.

Test Plan:
- Single frame, WIDTH=16, MSB_FIRST=1, out_ready=1, s_data=16'h000A:
  - out_valid rises 1 cycle after accept.
  - Bits are 12 zeros then 1,0,1,0. out_first on bit 0, out_last on bit 15, then IDLE.
  - With SERIAL_WORD_TX_REM5_EN, div5=1.
- Backpressure, s_data=16'hA5A5: toggle out_ready 1,0,0,1 repeatedly.
  - Bit order is unchanged. out_bit, out_first and out_last are stable while out_ready=0.
  - Exactly 16 transfers occur.
- Back-to-back, GAP_CYCLES=0, words 16'hFFFF then 16'h0001 offered continuously:
  - 32 consecutive transfers with no out_valid gap.
  - out_last on transfers 16 and 32; out_first on transfers 1 and 17.
  - s_ready low while the pending register is full.
- Gap, GAP_CYCLES=2, two queued words:
  - Exactly 2 cycles of out_valid=0 between the out_last transfer and the next out_first.
- LSB-first, MSB_FIRST=0, s_data=16'h0003:
  - Bits are 1,1 then 14 zeros.
- Reset mid-frame: assert rst_n=0 after 5 transfers with a pending word held.
  - All outputs take their reset values immediately (async).
  - After release, busy=0 and no bit is emitted until a new accept.
